// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan decoder: FSM encoding and a one-cold decode.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DIRECT,
        ST_BLANK,
        ST_DRIVE
    } state_t;

    localparam int MAX_N = 6;

    // Decode to the widest supported output; callers keep the low 2^N bits.
    function automatic logic [(1 << MAX_N)-1:0] dec_low(input logic [MAX_N-1:0] a);
        return ~({{((1 << MAX_N)-1){1'b0}}, 1'b1} << a);
    endfunction

endpackage

// File: rtl/scan_decoder_timer.sv
// Slot counter: counts 0..DIV-1, flags the terminal count, supports clear and hold.
module scan_timer #(
    parameter int DIV = 4,
    parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          hold,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt,
    output logic          tc
);

    assign tc = (cnt == CW'(DIV - 1));

    // Next count is exported so the parent can register outputs from it.
    always_comb begin
        cnt_nxt = cnt;
        if (clear)      cnt_nxt = '0;
        else if (!hold) cnt_nxt = tc ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end

endmodule

// File: rtl/scan_decoder.sv
// 3-enable one-cold decoder with a direct mode and a timed auto-scan mode.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int N     = 3,
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:3]        E,
    input  logic [N-1:0]      A,
    input  logic              mode,
    output logic [2**N-1:0]   Y,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int NY = 1 << N;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    if (N < 1 || N > MAX_N) begin : g_bad_n
        $error("scan_decoder: N must be in 1..6");
    end
    if (DIV < 1) begin : g_bad_div
        $error("scan_decoder: DIV must be >= 1");
    end
    if (BLANK < 0 || BLANK >= DIV) begin : g_bad_blank
        $error("scan_decoder: BLANK must be in 0..DIV-1");
    end

    state_t          state, state_nxt;
    logic            live, live_nxt;
    logic [N-1:0]    ptr, ptr_nxt;
    logic [NY-1:0]   y_nxt;
    logic [N-1:0]    idx_nxt, sel;
    logic            wrap_nxt;
    logic [MAX_N-1:0]        sel_ext;
    logic [(1<<MAX_N)-1:0]   dec_w;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            tc, in_blank;
    logic            en, scanning, cont, start, fresh, go_direct;

    assign en        = E[3] & ~E[2] & ~E[1];
    assign go_direct = en & ~mode;
    assign scanning  = (state == ST_BLANK) || (state == ST_DRIVE);
    assign cont      = en & mode & scanning;
    assign start     = en & mode & ~scanning;
    // live remembers an interrupted scan so an OFF->scan return resumes instead of reloading.
    assign fresh     = start & ~live;
    assign live_nxt  = mode & (live | en);

    scan_timer #(.DIV(DIV), .CW(CW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (start | go_direct),
        .hold    (~en),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt),
        .tc      (tc)
    );

    if (BLANK == 0) begin : g_noblank
        assign in_blank = 1'b0;
    end else begin : g_blank
        assign in_blank = (cnt_nxt < CW'(BLANK));
    end

    assign ptr_nxt  = fresh ? A : ((cont && tc) ? ptr + N'(1) : ptr);
    assign wrap_nxt = cont & tc & (ptr == '1);

    // State register (outputs registered alongside so they are glitch-free).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            live  <= 1'b0;
            ptr   <= '0;
            Y     <= '1;
            idx   <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= live_nxt;
            ptr   <= ptr_nxt;
            Y     <= y_nxt;
            idx   <= idx_nxt;
            wrap  <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en)        state_nxt = ST_OFF;
        else if (!mode) state_nxt = ST_DIRECT;
        else            state_nxt = in_blank ? ST_BLANK : ST_DRIVE;
    end

    always_comb begin
        sel              = (state_nxt == ST_DIRECT) ? A : ptr_nxt;
        sel_ext          = '0;
        sel_ext[N-1:0]   = sel;
        dec_w            = dec_low(sel_ext);
        y_nxt            = '1;
        idx_nxt          = idx;
        case (state_nxt)
            ST_DIRECT: begin y_nxt = dec_w[NY-1:0]; idx_nxt = A;       end
            ST_BLANK:  begin                        idx_nxt = ptr_nxt; end
            ST_DRIVE:  begin y_nxt = dec_w[NY-1:0]; idx_nxt = ptr_nxt; end
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Randomized and directed check of two scan_decoder builds against a slot-level reference model.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:3] E = 3'b101;
    logic [2:0] A = '0;
    logic       mode = 1'b0;

    logic [7:0] y0, y1;
    logic [2:0] idx0, idx1;
    logic       wrap0, wrap1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state per build: 0 = DIV 4/BLANK 1, 1 = DIV 1/BLANK 0.
    int         div_p[2]   = '{4, 1};
    int         blank_p[2] = '{1, 0};
    int         m_ptr[2], m_cnt[2], m_idx[2];
    bit         m_scan[2], m_live[2], m_wrap[2];
    logic [7:0] m_y[2];

    always #5 clk = ~clk;

    scan_decoder #(.N(3), .DIV(4), .BLANK(1)) dut0 (
        .clk(clk), .rst(rst), .E(E), .A(A), .mode(mode),
        .Y(y0), .idx(idx0), .wrap(wrap0)
    );

    scan_decoder #(.N(3), .DIV(1), .BLANK(0)) dut1 (
        .clk(clk), .rst(rst), .E(E), .A(A), .mode(mode),
        .Y(y1), .idx(idx1), .wrap(wrap1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_rst(input int d);
        m_ptr[d] = 0; m_cnt[d] = 0; m_idx[d] = 0;
        m_scan[d] = 0; m_live[d] = 0; m_wrap[d] = 0;
        m_y[d] = 8'hFF;
    endtask

    task automatic model_edge(input int d);
        bit en;
        en = E[3] && !E[2] && !E[1];
        if (rst) model_rst(d);
        else if (!en) begin
            m_scan[d] = 0; m_wrap[d] = 0; m_y[d] = 8'hFF;
            if (!mode) m_live[d] = 0;
        end else if (!mode) begin
            m_scan[d] = 0; m_live[d] = 0; m_wrap[d] = 0; m_cnt[d] = 0;
            m_y[d] = ~(8'd1 << A); m_idx[d] = int'(A);
        end else begin
            if (!m_scan[d]) begin
                if (!m_live[d]) m_ptr[d] = int'(A);
                m_cnt[d] = 0; m_wrap[d] = 0; m_scan[d] = 1; m_live[d] = 1;
            end else if (m_cnt[d] == div_p[d] - 1) begin
                m_cnt[d] = 0;
                m_wrap[d] = (m_ptr[d] == 7);
                m_ptr[d] = (m_ptr[d] + 1) % 8;
            end else begin
                m_cnt[d]++; m_wrap[d] = 0;
            end
            m_y[d] = (m_cnt[d] < blank_p[d]) ? 8'hFF : ~(8'd1 << m_ptr[d]);
            m_idx[d] = m_ptr[d];
        end
    endtask

    task automatic check_all();
        chk("y0", y0, m_y[0]);   chk("idx0", idx0, m_idx[0]); chk("wrap0", wrap0, m_wrap[0]);
        chk("y1", y1, m_y[1]);   chk("idx1", idx1, m_idx[1]); chk("wrap1", wrap1, m_wrap[1]);
        chk("onecold0", $countones(~y0) <= 1, 1);
        chk("onecold1", $countones(~y1) <= 1, 1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    initial begin
        int k;
        model_rst(0);
        model_rst(1);

        // Reset state
        step();
        chk("rst_y", y0, 8'hFF);
        chk("rst_idx", idx0, 3'd0);
        rst = 1'b0;

        // Direct decode, then disable via E[3]
        E = 3'b001; mode = 1'b0; A = 3'd5;
        step();
        chk("direct_y", y0, 8'hDF);
        chk("direct_idx", idx0, 3'd5);
        E = 3'b000;
        step();
        chk("off_y", y0, 8'hFF);

        // Scan from 6 through wrap
        E = 3'b001; mode = 1'b1; A = 3'd6;
        repeat (14) step();

        // Freeze mid-DRIVE of slot 3, then resume
        k = 0;
        while (!(m_ptr[0] == 3 && m_cnt[0] == 2) && k < 64) begin step(); k++; end
        chk("reach_ptr3", k < 64, 1);
        E = 3'b101;
        repeat (5) step();
        chk("freeze_idx", idx0, 3'd3);
        chk("freeze_y", y0, 8'hFF);
        E = 3'b001;
        step();
        chk("resume_blank", y0, 8'hFF);
        repeat (4) step();

        // Mode switch at ptr 2
        k = 0;
        while (!(m_ptr[0] == 2 && m_scan[0]) && k < 64) begin step(); k++; end
        chk("reach_ptr2", k < 64, 1);
        mode = 1'b0; A = 3'd7;
        step();
        chk("switch_y", y0, 8'h7F);

        // Async reset mid-scan
        mode = 1'b1; A = 3'd1;
        repeat (6) step();
        #2 rst = 1'b1;
        #1;
        model_rst(0);
        model_rst(1);
        check_all();
        step();
        rst = 1'b0;

        // Fresh scan from 0: the DIV=1 build walks one output per cycle
        A = 3'd0;
        repeat (20) step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            A = 3'($urandom);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            E = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b001;
            rst = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter N, default 3: address width; output count 2^N; legal range 1..6.
REQ-002 SHALL have parameter DIV, default 4: clock cycles per scan slot; legal range >= 1.
REQ-003 SHALL have parameter BLANK, default 1: dead cycles at the start of each scan slot; legal range 0..DIV-1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port E, input, 3 bits, indexed [1:3]: enables; E[1] and E[2] active-low, E[3] active-high.
REQ-007 SHALL have port A, input, N bits: address in direct mode, or start index when scan mode is entered.
REQ-008 SHALL have port mode, input, 1 bit: 0 selects direct decode, 1 selects auto-scan.
REQ-009 SHALL have port Y, output, 2^N bits: registered decoded outputs, active-low.
REQ-010 SHALL have port idx, output, N bits: registered index currently selected.
REQ-011 SHALL have port wrap, output, 1 bit: one-cycle pulse when the scan index wraps to 0.

Function
REQ-012 SHALL compute en = E[3] & ~E[2] & ~E[1] combinationally from the sampled inputs.
REQ-013 SHALL implement FSM states OFF, DIRECT, BLANK and DRIVE, all registered.
REQ-014 SHALL enter OFF whenever en=0, from any state, at the next edge; in OFF, Y = all ones, wrap = 0, and the scan counter and pointer hold.
REQ-015 SHALL, when en=1 and mode=0, enter DIRECT: Y = ~(1<<A) and idx = A, with one-cycle latency after the sampling edge.
REQ-016 SHALL, on any entry into scan (mode 0->1, or OFF->scan with mode=1), load ptr=A and cnt=0, then enter BLANK (or DRIVE if BLANK=0).
REQ-017 SHALL increment cnt every enabled scan cycle; at cnt=DIV-1, cnt SHALL return to 0 and ptr SHALL advance by 1 mod 2^N.
REQ-018 SHALL hold Y = all ones in BLANK (cnt < BLANK) and drive Y = ~(1<<ptr) in DRIVE (cnt >= BLANK); idx SHALL equal ptr throughout.
REQ-019 SHALL assert wrap for exactly one cycle, coincident with the first slot cycle of ptr=0 after ptr=2^N-1; wrap SHALL NOT assert on a scan-entry load of ptr=0.
REQ-020 SHALL resume a scan from OFF with the held ptr and cnt=0 when en returns and mode is still 1 (a resume is not a fresh entry, so ptr is not reloaded from A).
REQ-021 SHALL have a DIRECT-mode sample, taken on the edge where mode goes 1->0, take effect on the next cycle; scan state is discarded.
REQ-022 SHALL, with DIV=1 and BLANK=0, advance ptr every cycle with no blanking.
REQ-023 SHALL never assert more than one Y bit low in any cycle.

Reset
REQ-024 SHALL, while rst=1, asynchronously force Y = all ones, idx = 0, wrap = 0, cnt = 0, ptr = 0 and state = OFF.
REQ-025 SHALL, on the first edge after rst deasserts, evaluate en and mode normally; a rst pulse mid-scan SHALL abandon the current slot.

Structure
REQ-026 SHALL place the FSM state enumeration and a one-hot-low decode function (N -> 2^N) in the shared package scan_decoder_pkg.
REQ-027 SHALL implement the slot counter (cnt, terminal-count flag, hold input) as sub-module scan_timer, parameterised by DIV.
REQ-028 SHALL reject illegal parameter values (DIV < 1, BLANK >= DIV, N outside 1..6) with an elaboration-time error.

Verification (N=3, DIV=4, BLANK=1 unless stated)
REQ-029 SHALL cover direct decode: E=[1]0,[2]0,[3]1, mode=0, A=5 -> Y=8'b1101_1111 and idx=5 one cycle later; set E[3]=0 -> Y=8'hFF next cycle.
REQ-030 SHALL cover scan sequence: mode=1, A=6 -> per slot, 1 cycle Y=FF then 3 cycles of Y bit 6 low, then slot 7, then slot 0 with wrap high for 1 cycle at that slot's first cycle.
REQ-031 SHALL cover freeze/resume: mid-DRIVE of ptr=3, set E[1]=1 for 5 cycles -> Y=FF and idx=3 held; re-enable -> BLANK then DRIVE of slot 3 (full slot length).
REQ-032 SHALL cover async reset: assert rst between edges mid-scan -> Y=FF and idx=0 immediately, wrap=0.
REQ-033 SHALL cover DIV=1, BLANK=0 build: mode=1, A=0 -> Y low bit walks 0..7, wrap high on every 8th cycle, never at entry.
REQ-034 SHALL cover mode switch: scan at ptr=2, set mode=0 with A=7 -> Y=8'h7F on the next cycle, with no blank cycle.
